instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the instruction fetch slice.
//   XLEN             - datapath / PC width
//   RESET_PC_DEFAULT - default word-indexed PC loaded at reset
//   fetch_state_e    - fetch control state (StRun / StDrain)
//   pc_next()        - word-indexed PC increment, modulo 2^XLEN
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0;

  // StRun: normal fetch. StDrain: stale responses still owed by memory.
  typedef enum logic {
    StRun   = 1'b0,
    StDrain = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr} pairs used as the prefetch queue.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   i_push, i_pc,     - write {i_pc, i_instr} at the tail
//   i_instr
//   i_pop             - drop the head entry
//   i_flush           - empty the queue (wins over push and pop)
//   o_pc, o_instr     - head entry; zero while empty
//   o_count           - number of stored entries, 0..DEPTH
//   o_empty, o_full   - status flags
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  input  logic            i_pop,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic [CW-1:0]   o_count,
  output logic            o_empty,
  output logic            o_full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full queue can still accept a push in the cycle its head leaves.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && !reset) begin
      r_pc_mem[r_wr_ptr]    <= i_pc;
      r_instr_mem[r_wr_ptr] <= i_instr;
    end
  end

  assign o_pc    = o_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign o_instr = o_empty ? '0 : r_instr_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-based instruction prefetcher feeding a decoder.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   redirect_valid, redirect_pc   - taken branch/jump: flush and refetch from redirect_pc
//   imem_req_valid/ready/addr     - fetch request to instruction memory (word address)
//   imem_rsp_valid, imem_rsp_data - in-order read data, never backpressured
//   inst_valid/ready/data/pc      - instruction stream to the decoder
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] r_fpc;       // next address to request
  logic [XLEN-1:0] r_rsp_pc;    // PC owned by the next live response
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop_cnt;
  fetch_state_e    r_state;

  fetch_state_e    w_state_d;
  logic [CW-1:0]   w_drop_cnt_d;
  logic [CW-1:0]   w_qcount;
  logic            w_q_empty;
  logic            w_q_full;
  logic            w_credit_ok;
  logic            w_req_fire;
  logic            w_rsp_seen;
  logic            w_rsp_live;
  logic            w_pop;

  // Queue slots plus outstanding requests never exceed QDEPTH, so every
  // response is guaranteed a slot.
  assign w_credit_ok    = ({1'b0, w_qcount} + {1'b0, r_inflight}) < (CW + 1)'(QDEPTH);
  assign imem_req_valid = ~reset & ~redirect_valid & w_credit_ok;
  assign imem_req_addr  = r_fpc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_rsp_seen = imem_rsp_valid & ~reset;
  assign w_rsp_live = w_rsp_seen & ~redirect_valid & (r_state == StRun);

  assign inst_valid = ~w_q_empty;
  assign w_pop      = inst_valid & inst_ready;

  // Drop accounting. r_inflight already includes stale requests, so on a
  // redirect everything outstanding becomes stale, minus a response that
  // is being discarded this very cycle.
  always_comb begin
    w_state_d    = r_state;
    w_drop_cnt_d = r_drop_cnt;
    if (redirect_valid) begin
      w_drop_cnt_d = r_inflight - CW'(w_rsp_seen);
    end else if (w_rsp_seen && (r_state == StDrain)) begin
      w_drop_cnt_d = r_drop_cnt - CW'(1);
    end
    unique case (r_state)
      StRun:   if (w_drop_cnt_d != '0) w_state_d = StDrain;
      StDrain: if (w_drop_cnt_d == '0) w_state_d = StRun;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StRun;
      r_drop_cnt <= '0;
      r_inflight <= '0;
      r_fpc      <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
    end else begin
      r_state    <= w_state_d;
      r_drop_cnt <= w_drop_cnt_d;
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_seen);
      if (redirect_valid) begin
        r_fpc    <= redirect_pc;
        r_rsp_pc <= redirect_pc;
      end else begin
        if (w_req_fire) r_fpc    <= pc_next(r_fpc);
        if (w_rsp_live) r_rsp_pc <= pc_next(r_rsp_pc);
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rsp_live),
    .i_pc    (r_rsp_pc),
    .i_instr (imem_rsp_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_pc    (inst_pc),
    .o_instr (inst_data),
    .o_count (w_qcount),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  // The credit rule makes a live response into a full queue impossible.
  a_no_drop_on_full : assert property (@(posedge clk) disable iff (reset)
    !(w_rsp_live && w_q_full && !w_pop));

endmodule
